// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one combinational ALU between two requesters
//   req0_*/req1_* : valid/ready operation channels (val1, val2, sel)
//   rsp0_*/rsp1_* : valid/ready response channels; rsp_result/rsp_flag shared by both
//   alu_*         : registered operands/select out, result/flag back from the ALU
//   busy, grant_id, op_count : status (op_count wraps silently)
module alu_share_ctrl #(
   parameter int WIDTH       = 8,
   parameter int SEL_W       = 4,
   parameter int EXEC_CYCLES = 1,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_val1,
   input  logic [WIDTH-1:0] req0_val2,
   input  logic [SEL_W-1:0] req0_sel,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_val1,
   input  logic [WIDTH-1:0] req1_val2,
   input  logic [SEL_W-1:0] req1_sel,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_flag,
   output logic [WIDTH-1:0] alu_val1,
   output logic [WIDTH-1:0] alu_val2,
   output logic [SEL_W-1:0] alu_select,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_flag,
   output logic             busy,
   output logic             grant_id,
   output logic [CNT_W-1:0] op_count
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   localparam logic [3:0] LAST = 4'(EXEC_CYCLES);
   state_t     state;
   logic       last_grant;
   logic [3:0] exec_cnt;
   logic       pick1;
   logic       rsp_take;
   // requester 1 wins when alone, or on a tie when requester 0 was served last
   assign pick1      = req1_valid & (~req0_valid | ~last_grant);
   assign req0_ready = (state == IDLE) & req0_valid & ~pick1;
   assign req1_ready = (state == IDLE) & pick1;
   assign rsp_take   = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         exec_cnt   <= '0;
         alu_val1   <= '0;
         alu_val2   <= '0;
         alu_select <= '0;
         grant_id   <= 1'b0;
         busy       <= 1'b0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp_result <= '0;
         rsp_flag   <= 1'b0;
         op_count   <= '0;
      end else begin
         case (state)
            IDLE: if (req0_ready | req1_ready) begin
               alu_val1   <= pick1 ? req1_val1 : req0_val1;
               alu_val2   <= pick1 ? req1_val2 : req0_val2;
               alu_select <= pick1 ? req1_sel : req0_sel;
               grant_id   <= pick1;
               last_grant <= pick1;
               exec_cnt   <= 4'd1;
               busy       <= 1'b1;
               state      <= EXEC;
            end
            EXEC: if (exec_cnt == LAST) begin
               rsp_result <= alu_result;
               rsp_flag   <= alu_flag;
               rsp0_valid <= ~grant_id;
               rsp1_valid <= grant_id;
               state      <= RESP;
            end else begin
               exec_cnt <= exec_cnt + 4'd1;
            end
            RESP: if (rsp_take) begin
               rsp0_valid <= 1'b0;
               rsp1_valid <= 1'b0;
               busy       <= 1'b0;
               op_count   <= op_count + 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed bench over three configurations (E=1/C=16, E=3/C=2, E=2/C=16)
module tb_alu_share_ctrl;
   logic clk = 1'b0, rst = 1'b1;
   logic req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
   logic [7:0] r0v1 = 0, r0v2 = 0, r1v1 = 0, r1v2 = 0;
   logic [3:0] r0s = 0, r1s = 0;
   logic rdy0[3], rdy1[3], v0[3], v1[3], bsy[3], gid[3], rflag[3], aflag[3];
   logic [7:0] res[3], av1[3], av2[3], ares[3];
   logic [3:0] asel[3];
   logic [15:0] cnt[3];
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   // reference ALU: {flag, result}; flag is carry/borrow for add/sub, zero otherwise
   function automatic logic [8:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
      logic [8:0] t;
      t = s == 0 ? {1'b0, a} + {1'b0, b} : s == 1 ? {1'b0, a} - {1'b0, b} :
          s == 2 ? {1'b0, a & b} : s == 3 ? {1'b0, a | b} : s == 4 ? {1'b0, a ^ b} :
          {1'b0, a + {4'b0, s}};
      return s < 2 ? t : {t[7:0] == 8'd0, t[7:0]};
   endfunction
   for (genvar g = 0; g < 3; g++) begin : d
      localparam int E = g == 1 ? 3 : g == 2 ? 2 : 1;
      localparam int C = g == 1 ? 2 : 16;
      logic [C-1:0] oc;
      assign {aflag[g], ares[g]} = alu(av1[g], av2[g], asel[g]);
      assign cnt[g] = 16'(oc);
      alu_share_ctrl #(.EXEC_CYCLES(E), .CNT_W(C)) u (
         .clk(clk), .rst(rst),
         .req0_valid(req0_valid), .req0_ready(rdy0[g]), .req0_val1(r0v1), .req0_val2(r0v2), .req0_sel(r0s),
         .req1_valid(req1_valid), .req1_ready(rdy1[g]), .req1_val1(r1v1), .req1_val2(r1v2), .req1_sel(r1s),
         .rsp0_valid(v0[g]), .rsp0_ready(rsp0_ready), .rsp1_valid(v1[g]), .rsp1_ready(rsp1_ready),
         .rsp_result(res[g]), .rsp_flag(rflag[g]),
         .alu_val1(av1[g]), .alu_val2(av2[g]), .alu_select(asel[g]),
         .alu_result(ares[g]), .alu_flag(aflag[g]),
         .busy(bsy[g]), .grant_id(gid[g]), .op_count(oc)
      );
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(negedge clk);
      #1;
   endtask
   task automatic do_reset;
      @(negedge clk);
      rst = 1;
      {req0_valid, req1_valid, rsp0_ready, rsp1_ready} = '0;
      #2;
      rst = 0;
      #1;
   endtask
   function automatic logic sig(input int k, input int w);
      return w == 0 ? rdy0[k] : w == 1 ? rdy1[k] : w == 2 ? v0[k] : v1[k];
   endfunction
   task automatic wait_sig(input int k, input int w, input string tag);
      int n;
      n = 0;
      while (!sig(k, w) && n < 20) begin
         tick();
         n++;
      end
      chk(tag, 32'(sig(k, w)), 1);
   endtask
   initial begin
      logic [8:0] m;
      logic [7:0] cap;
      #12;
      chk("rst_busy", 32'(bsy[0]), 0);
      chk("rst_rsp0", 32'(v0[0]), 0);
      chk("rst_rsp1", 32'(v1[0]), 0);
      chk("rst_alu", {av1[0], av2[0], 4'(asel[0])}, 0);
      chk("rst_res", {res[0], 7'(rflag[0])}, 0);
      chk("rst_gid", 32'(gid[0]), 0);
      chk("rst_cnt", 32'(cnt[0]), 0);
      rst = 0;
      // single op, E=1
      @(negedge clk);
      req0_valid = 1; r0v1 = 8'h0A; r0v2 = 8'h02; r0s = 0;
      #1;
      chk("one_rdy0", 32'(rdy0[0]), 1);
      chk("one_rdy1", 32'(rdy1[0]), 0);
      @(negedge clk);
      req0_valid = 0;
      #1;
      chk("one_av1", 32'(av1[0]), 32'h0A);
      chk("one_av2", 32'(av2[0]), 32'h02);
      chk("one_busy", 32'(bsy[0]), 1);
      chk("one_v0_early", 32'(v0[0]), 0);
      tick();
      chk("one_v0", 32'(v0[0]), 1);
      chk("one_res", 32'(res[0]), 32'h0C);
      chk("one_flag", 32'(rflag[0]), 0);
      chk("one_v1", 32'(v1[0]), 0);
      rsp0_ready = 1;
      @(negedge clk);
      rsp0_ready = 0;
      #1;
      chk("one_done", 32'(v0[0]), 0);
      chk("one_idle", 32'(bsy[0]), 0);
      chk("one_cnt", 32'(cnt[0]), 1);
      // fairness, E=1
      do_reset();
      r0v1 = 1; r0v2 = 1; r0s = 0; r1v1 = 2; r1v2 = 3; r1s = 2;
      req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
      #1;
      for (int i = 0; i < 6; i++) begin
         for (int n = 0; n < 10 && !(rdy0[0] | rdy1[0]); n++) tick();
         chk("fair_rdy", 32'(rdy0[0] | rdy1[0]), 1);
         chk("fair_pick", 32'(rdy1[0]), 32'(i % 2));
         tick();
         chk("fair_gid", 32'(gid[0]), 32'(i % 2));
      end
      tick();
      tick();
      chk("fair_cnt", 32'(cnt[0]), 6);
      // backpressure on response 1, E=1
      do_reset();
      @(negedge clk);
      req1_valid = 1; r1v1 = 8'h30; r1v2 = 8'h05; r1s = 1;
      #1;
      chk("bp_rdy1", 32'(rdy1[0]), 1);
      @(negedge clk);
      req1_valid = 0; req0_valid = 1; r0v1 = 8'h0A; r0v2 = 8'h02; r0s = 0;
      #1;
      chk("bp_rdy0_exec", 32'(rdy0[0]), 0);
      tick();
      chk("bp_v1", 32'(v1[0]), 1);
      chk("bp_v0", 32'(v0[0]), 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold_v1", 32'(v1[0]), 1);
         chk("bp_hold_res", {res[0], 7'(rflag[0])}, {8'h2B, 7'd0});
         chk("bp_hold_rdy0", 32'(rdy0[0]), 0);
      end
      rsp1_ready = 1;
      #1;
      chk("bp_rdy0_resp", 32'(rdy0[0]), 0);
      @(negedge clk);
      rsp1_ready = 0;
      #1;
      chk("bp_v1_drop", 32'(v1[0]), 0);
      chk("bp_rdy0_after", 32'(rdy0[0]), 1);
      chk("bp_cnt", 32'(cnt[0]), 1);
      @(negedge clk);
      req0_valid = 0;
      #1;
      chk("bp_gid", 32'(gid[0]), 0);
      chk("bp_av1", 32'(av1[0]), 32'h0A);
      // select sweep, E=2
      do_reset();
      r0v1 = 8'h0A; r0v2 = 8'h02;
      for (int s = 0; s < 16; s++) begin
         @(negedge clk);
         req0_valid = 1; r0s = 4'(s);
         #1;
         chk("sw_acc", 32'(rdy0[2]), 1);
         @(negedge clk);
         req0_valid = 0;
         #1;
         chk("sw_v0_t1", 32'(v0[2]), 0);
         tick();
         chk("sw_v0_t2", 32'(v0[2]), 0);
         cap = ares[2];
         tick();
         chk("sw_v0_t3", 32'(v0[2]), 1);
         m = alu(8'h0A, 8'h02, 4'(s));
         chk("sw_res", 32'(res[2]), 32'(m[7:0]));
         chk("sw_flag", 32'(rflag[2]), 32'(m[8]));
         chk("sw_cap", 32'(res[2]), 32'(cap));
         rsp0_ready = 1;
         @(negedge clk);
         rsp0_ready = 0;
      end
      // op_count wrap, E=3, CNT_W=2
      do_reset();
      rsp0_ready = 1; r0v1 = 1; r0v2 = 1; r0s = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         req0_valid = 1;
         #1;
         wait_sig(1, 0, "wr_acc");
         @(negedge clk);
         req0_valid = 0;
         #1;
         wait_sig(1, 2, "wr_rsp");
         tick();
         chk("wr_cnt", 32'(cnt[1]), 32'((i + 1) % 4));
      end
      // reset during EXEC, E=3
      rsp0_ready = 0;
      @(negedge clk);
      req0_valid = 1; r0v1 = 8'h55; r0v2 = 8'hAA; r0s = 3;
      #1;
      chk("mr_acc", 32'(rdy0[1]), 1);
      @(negedge clk);
      req0_valid = 0;
      #1;
      chk("mr_busy", 32'(bsy[1]), 1);
      chk("mr_av1", 32'(av1[1]), 32'h55);
      tick();
      rst = 1;
      #1;
      chk("mr_busy0", 32'(bsy[1]), 0);
      chk("mr_alu0", {av1[1], av2[1], 4'(asel[1])}, 0);
      chk("mr_cnt0", 32'(cnt[1]), 0);
      chk("mr_rsp0", {v0[1], v1[1], 8'(res[1]), rflag[1], gid[1]}, 0);
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("mr_no_rsp", 32'(v0[1]), 0);
      end
      req0_valid = 1; req1_valid = 1;
      #1;
      chk("mr_tie0", 32'(rdy0[1]), 1);
      chk("mr_tie1", 32'(rdy1[1]), 0);
      req0_valid = 0; req1_valid = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Controller that shares one 8-bit combinational ALU (val1/val2/select in, result/flag out) between two requesters.
- Round-robin arbitration; operands are latched and driven onto the ALU from registers.
- Waits a programmable settle time, captures result/flag, and returns them to the granted requester over a valid/ready response channel.
- Sits between the ALU instance and two client blocks, e.g. a sequencer and a test/debug port.

Parameters:
- WIDTH, 8, operand/result width.
- SEL_W, 4, ALU select width.
- EXEC_CYCLES, 1, ALU settle cycles before capture. Legal range 1..15.
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_val1, req0_val2  in  WIDTH  requester 0 operands.
- req0_sel  in  SEL_W  requester 0 ALU select.
- req1_valid, req1_ready, req1_val1, req1_val2, req1_sel  as requester 0, for requester 1.
- rsp0_valid  out  1  response to requester 0 valid.
- rsp0_ready  in  1  requester 0 takes response.
- rsp1_valid  out  1  response to requester 1 valid.
- rsp1_ready  in  1  requester 1 takes response.
- rsp_result  out  WIDTH  captured ALU result, shared by both responses.
- rsp_flag  out  1  captured ALU flag.
- alu_val1, alu_val2  out  WIDTH  registered operands to ALU.
- alu_select  out  SEL_W  registered select to ALU.
- alu_result  in  WIDTH  ALU result.
- alu_flag  in  1  ALU flag.
- busy  out  1  high whenever state is not IDLE.
- grant_id  out  1  requester currently owning the ALU.
- op_count  out  CNT_W  completed operations, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; all outputs 0.
  - last_grant=1, so requester 0 wins the first tie.
  - exec counter 0.
- FSM states:
  - IDLE: choose grant.
    - Only one reqN_valid high → grant N.
    - Both high → grant the requester != last_grant.
    - reqN_ready = (state==IDLE) & granted N; combinational, one cycle only.
    - On handshake: latch val1/val2/sel into alu_* registers, grant_id=N, last_grant=N, → EXEC.
    - No valid → stay; alu_* hold previous values.
  - EXEC: alu_* stable.
    - Counter runs 1..EXEC_CYCLES.
    - In the last EXEC cycle, capture alu_result/alu_flag at the clock edge into rsp_result/rsp_flag, → RESP.
  - RESP: rspN_valid=1 for N=grant_id; the other rsp valid stays 0.
    - rsp_result/rsp_flag held stable until rspN_valid & rspN_ready.
    - On handshake: op_count+1, → IDLE.
- Latency (EXEC_CYCLES=E):
  - Accept at cycle T.
  - alu_* valid from T+1.
  - rspN_valid from T+E+1.
  - Earliest next accept is the cycle after the response handshake.
  - E=1 gives max throughput of one op per 3 cycles.
- Requester rules:
  - Hold valid and operands stable until ready.
  - Deasserting valid before ready is legal; the operation is simply not taken.
  - The non-granted requester is never acked while busy.
- Response channel:
  - rspN_ready while rspN_valid low is ignored.
  - Response may be held indefinitely; this stalls both requesters.
- op_count wraps from all-ones to 0 with no flag.
- Reset mid-operation:
  - Operation abandoned, no response issued, op_count cleared.
  - Next tie goes to requester 0.
- Result and flag are passed through unmodified; no width change. The controller never interprets select.

Test Plan:
- Reset: assert rst mid-cycle with EXEC_CYCLES=3 during EXEC → all outputs 0 immediately, busy=0, op_count=0; after release, simultaneous requests grant req0 first.
- Single op: req0 val1=0x0A, val2=0x02, sel=0 (ALU add) accepted at T → alu_val1=0x0A, alu_val2=0x02 at T+1; rsp0_valid at T+2 with rsp_result=0x0C, flag=0; rsp1_valid stays 0.
- Fairness: both requesters valid continuously, rsp ready tied high, 6 ops → grant_id sequence 0,1,0,1,0,1; op_count=6.
- Backpressure: rsp1_ready low for 5 cycles while req0_valid high → rsp1_valid and result held constant, req0_ready stays 0; req0 accepted the cycle after the rsp1 handshake.
- Sweep: req0 loops sel 0..15 on 0x0A/0x02, EXEC_CYCLES=2 → each rsp_result equals alu_result sampled at capture; rsp0_valid rises exactly 3 cycles after each accept.
- Wrap: CNT_W=2, five completed ops → op_count sequence 1,2,3,0,1.
